// File: rtl/float_to_pcm_if.sv
// float_to_pcm_if: float sample input and PCM result output bundle.
interface float_to_pcm_if #(
    parameter int OUT_W = 32
);
    logic [31:0]      float_val;
    logic             sample_ready;
    logic [OUT_W-1:0] output_sample;
    logic             output_ready;
    logic             sat_flag;
    logic             nan_flag;

    modport master (
        output float_val, sample_ready,
        input  output_sample, output_ready, sat_flag, nan_flag
    );

    modport slave (
        input  float_val, sample_ready,
        output output_sample, output_ready, sat_flag, nan_flag
    );
endinterface

// File: rtl/float_to_pcm.sv
// float_to_pcm: 3-stage IEEE-754 single -> signed PCM converter.
// Stage 1 captures and classifies, stage 2 aligns the mantissa to an
// integer magnitude plus round bit, stage 3 rounds, clamps and signs.
module float_to_pcm #(
    parameter int OUT_W = 32,
    parameter int ROUND = 1
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    float_to_pcm_if.slave bus
);
    localparam int MW = OUT_W + 1;
    // Shift window keeps {mant,guard} intact and leaves at least one bit
    // above the magnitude for overflow detection.
    localparam int XW = (OUT_W + 3 > 25) ? OUT_W + 3 : 25;
    localparam logic signed [8:0] E_TOP   = 9'(OUT_W - 1);
    localparam logic [MW-1:0]     POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [MW-1:0]     NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]  OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [7:0]  in_exp;
    logic [22:0] in_frac;

    logic        s1_valid, s1_sign, s1_zero, s1_inf, s1_nan;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;

    logic signed [8:0] e;
    logic [4:0]        shl_amt, shr_amt;
    logic [XW-1:0]     ext, shifted;
    logic              ovf;
    logic [MW-1:0]     mag_n;
    logic              rnd_n, sat_n, nan_n;

    logic          s2_valid, s2_sign, s2_rnd, s2_sat, s2_nan;
    logic [MW-1:0] s2_mag;

    logic             rnd_add;
    logic [MW-1:0]    mag_rnd;
    logic [OUT_W-1:0] sample_n;
    logic             sat_o, nan_o;

    assign in_exp  = bus.float_val[30:23];
    assign in_frac = bus.float_val[22:0];

    // Stage 1: capture the fields and classify zero/denormal, Inf and NaN.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= 8'd0;
            s1_mant  <= 24'd0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_nan   <= 1'b0;
        end else begin
            s1_valid <= bus.sample_ready;
            if (bus.sample_ready) begin
                s1_sign <= bus.float_val[31];
                s1_exp  <= in_exp;
                s1_mant <= {(in_exp != 8'd0), in_frac};
                s1_zero <= (in_exp == 8'd0);
                s1_inf  <= (in_exp == 8'hFF) && (in_frac == 23'd0);
                s1_nan  <= (in_exp == 8'hFF) && (in_frac != 23'd0);
            end
        end
    end

    // Stage 2 logic: unbias the exponent and shift the mantissa into place.
    // The guard bit below the mantissa becomes the round bit on right shifts.
    always_comb begin
        e       = $signed({1'b0, s1_exp}) - 9'sd127;
        shl_amt = e[4:0] - 5'd23;
        shr_amt = 5'd23 - e[4:0];
        ext     = XW'({s1_mant, 1'b0});
        shifted = (e >= 9'sd23) ? (ext << shl_amt) : (ext >> shr_amt);
        ovf     = |shifted[XW-1:MW+1];
        mag_n   = shifted[MW:1];
        rnd_n   = (e < 9'sd23) && shifted[0];
        sat_n   = 1'b0;
        nan_n   = 1'b0;
        if (s1_nan) begin
            mag_n = '0;
            rnd_n = 1'b0;
            nan_n = 1'b1;
        end else if (s1_inf) begin
            mag_n = '1;
            rnd_n = 1'b0;
            sat_n = 1'b1;
        end else if (s1_zero || (e < -9'sd1)) begin
            mag_n = '0;
            rnd_n = 1'b0;
        end else if ((e > E_TOP) || ovf) begin
            mag_n = '1;
            rnd_n = 1'b0;
            sat_n = 1'b1;
        end else if (e == E_TOP) begin
            // Only -2^(OUT_W-1) exactly is representable at this exponent.
            sat_n = !(s1_sign && (s1_mant[22:0] == 23'd0));
        end
    end

    // Stage 2 register: aligned magnitude, round bit and classification.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_rnd   <= 1'b0;
            s2_sat   <= 1'b0;
            s2_nan   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_mag  <= mag_n;
                s2_rnd  <= rnd_n;
                s2_sat  <= sat_n;
                s2_nan  <= nan_n;
            end
        end
    end

    // Stage 3 logic: round half away from zero on the magnitude, clamp, sign.
    always_comb begin
        rnd_add  = (ROUND != 0) && s2_rnd;
        mag_rnd  = s2_mag + MW'(rnd_add);
        sample_n = '0;
        sat_o    = 1'b0;
        nan_o    = 1'b0;
        if (s2_nan) begin
            nan_o = 1'b1;
        end else if (s2_sat) begin
            sample_n = s2_sign ? OUT_MIN : OUT_MAX;
            sat_o    = 1'b1;
        end else if (!s2_sign && (mag_rnd > POS_LIM)) begin
            sample_n = OUT_MAX;
            sat_o    = 1'b1;
        end else if (s2_sign && (mag_rnd > NEG_LIM)) begin
            sample_n = OUT_MIN;
            sat_o    = 1'b1;
        end else if (s2_sign) begin
            sample_n = OUT_W'(0) - mag_rnd[OUT_W-1:0];
        end else begin
            sample_n = mag_rnd[OUT_W-1:0];
        end
    end

    // Stage 3 register: publish the result and pulse output_ready.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bus.output_sample <= '0;
            bus.output_ready  <= 1'b0;
            bus.sat_flag      <= 1'b0;
            bus.nan_flag      <= 1'b0;
        end else begin
            bus.output_ready <= s2_valid;
            if (s2_valid) begin
                bus.output_sample <= sample_n;
                bus.sat_flag      <= sat_o;
                bus.nan_flag      <= nan_o;
            end
        end
    end
endmodule

// File: doc/float_to_pcm.md
Name: float_to_pcm

Overview:
Converts IEEE-754 single-precision results from the float multiply path back to signed fixed-point PCM samples for the audio output side of the mic array. It is the float-to-integer decoder that pairs with the integer-to-float front end that consumes sample_aud. It is a 3-stage streaming pipeline that accepts one sample per clock, with saturation, rounding, and NaN/Inf handling.

Parameters:
OUT_W, 32, output sample width in bits (legal range 8..32)
ROUND, 1, 1 = round half away from zero; 0 = truncate toward zero

Ports:
clk_clk  input  1  system clock, all state on rising edge
reset_reset_n  input  1  asynchronous active-low reset
float_val  input  32  IEEE-754 single-precision value to convert
sample_ready  input  1  float_val valid this cycle; single-cycle pulse, may be asserted every cycle
output_sample  output  OUT_W  signed two's-complement result; held until the next result
output_ready  output  1  one-cycle pulse when output_sample is updated
sat_flag  output  1  result was clamped (out of range or ±Inf); valid with output_ready, held with output_sample
nan_flag  output  1  input was NaN; valid with output_ready, held with output_sample

Behaviour:
- Reset (asynchronous, any time): output_sample=0, output_ready=0, sat_flag=0, nan_flag=0, all pipeline valid bits=0. In-flight samples are discarded and produce no output_ready after reset releases.
- Latency: sample_ready in cycle N gives output_ready in cycle N+3. Throughput is 1 per cycle with no stalls and no backpressure. Idle cycles insert no output_ready.
- Stage 1 (capture on sample_ready): register sign, exp[7:0], and mant = {hidden,frac[22:0]}, where hidden = (exp!=0).
  - exp==0 (zero or denormal): flush to zero.
  - exp==255: classify as Inf (frac==0) or NaN (frac!=0).
- Stage 2 (align): e = exp-127, signed 9 bits.
  - NaN: magnitude=0, nan=1, sat=0.
  - Inf, or e>OUT_W-1: magnitude saturates, sat=1.
  - e==OUT_W-1: sat=1, except sign=1 with frac==0, which is exactly -2^(OUT_W-1): no saturation, flag 0.
  - e<-1: magnitude=0, round bit=0.
  - e>=23: magnitude = mant << (e-23).
  - Else: magnitude = mant >> (23-e); round bit = last bit shifted out.
- Stage 3 (round/sign/clamp):
  - If ROUND=1, add round bit to magnitude; ties round away from zero, so 0.5→1 and -2.5→-3.
  - Positive magnitude > 2^(OUT_W-1)-1 after rounding: clamp to 2^(OUT_W-1)-1, sat=1.
  - Negative magnitude > 2^(OUT_W-1): clamp to -2^(OUT_W-1), sat=1.
  - Apply sign by two's-complement negate. -0.0 gives 0.
  - Register output_sample, sat_flag, nan_flag. Pulse output_ready.
- Saturated values: +max = 2^(OUT_W-1)-1 (0x7FFFFFFF at OUT_W=32); -min = -2^(OUT_W-1) (0x80000000).
- Arithmetic: internal magnitude is OUT_W+1 bits wide. No truncation warnings are permitted on the shift path.
- sample_ready asserted during reset is ignored.

Test Plan:
- OUT_W=32, ROUND=1, float_val=0xC4F68000 (-1972.0) with one sample_ready pulse -> 3 cycles later output_ready=1, output_sample=0xFFFFF84C, sat_flag=0, nan_flag=0.
- 0x3FB4CE08 (~1.4125) -> 0x00000001. 0x3ECBD4B4 (~0.398) -> 0x00000000. 0x3F000000 (0.5) -> 0x00000001. 0xBFC00000 (-1.5) -> 0xFFFFFFFE. Repeat with ROUND=0 -> 1, 0, 0, 0xFFFFFFFF.
- Range edges: 0x4F000000 (2^31) -> 0x7FFFFFFF, sat=1. 0xCF000000 (-2^31) -> 0x80000000, sat=0. 0x7F800000 (+Inf) -> 0x7FFFFFFF, sat=1. 0xFF800000 (-Inf) -> 0x80000000, sat=1. 0x7FC00000 (NaN) -> 0, nan=1. 0x80000000 (-0.0) -> 0. 0x00000001 (denormal) -> 0.
- OUT_W=16, ROUND=1: 0x46FFFF00 (32767.5) -> 0x7FFF, sat=1. 0xC7000000 (-32768) -> 0x8000, sat=0.
- Back-to-back: 8 consecutive sample_ready cycles with distinct values -> 8 consecutive output_ready cycles, in order, starting 3 cycles after the first input.
- Reset mid-flight: two samples in flight, then assert reset_reset_n=0 asynchronously between clock edges -> outputs go to 0 immediately; no output_ready after release; the next new sample converts correctly with latency 3.
